// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: one 33-bit adder per step, DATA_W steps,
// then a single sign-fix cycle that writes HI/LO and pulses done.
module mdu_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic              rd_hilo,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int CNT_W = $clog2(DATA_W);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   opb;      // multiplicand or divisor magnitude
    logic                is_div, neg_q, neg_r;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                done_q;

    logic              launch, sgn_a, sgn_b;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W:0]   add_a, add_b, add_sum;
    logic              add_cin;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0] hi_res, lo_res;

    assign launch = (state == IDLE) && start && !flush && !op[2];
    assign sgn_a  = op[0] && SrcA[DATA_W-1];
    assign sgn_b  = op[0] && SrcB[DATA_W-1];
    assign mag_a  = sgn_a ? -SrcA : SrcA;
    assign mag_b  = sgn_b ? -SrcB : SrcB;

    // The single shared adder: add-if-lsb for multiply, trial subtract for divide.
    always_comb begin
        if (is_div) begin
            add_a   = acc[2*DATA_W-1:DATA_W-1];
            add_b   = ~{1'b0, opb};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc[2*DATA_W-1:DATA_W]};
            add_b   = acc[0] ? {1'b0, opb} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_a + add_b + {{DATA_W{1'b0}}, add_cin};
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        if (is_div) begin
            hi_res = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            lo_res = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        end else begin
            hi_res = prod_fix[2*DATA_W-1:DATA_W];
            lo_res = prod_fix[DATA_W-1:0];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(DATA_W-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == FIX) && !flush;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        acc    <= {{DATA_W{1'b0}}, op[1] ? mag_a : mag_b};
                        opb    <= op[1] ? mag_b : mag_a;
                        // Divide by zero keeps the quotient all ones regardless of sign.
                        neg_q  <= (sgn_a ^ sgn_b) && (!op[1] || (SrcB != '0));
                        neg_r  <= sgn_a;
                    end else if (start && !flush && op == 3'b100) begin
                        hi_q <= SrcA;
                    end else if (start && !flush && op == 3'b101) begin
                        lo_q <= SrcA;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (add_sum[DATA_W]) acc <= {acc[2*DATA_W-2:0], 1'b0};
                        else acc <= {add_sum[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                    end else begin
                        acc <= {add_sum, acc[DATA_W-1:1]};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_q <= hi_res;
                        lo_q <= lo_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy && (start || rd_hilo);
    assign done  = done_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule
